data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressable data memory with a fixed-latency request/response handshake.
// One request is in flight at a time. Stores commit on the accept edge. Loads
// read the RAM on the accept edge and are formatted (sign/zero extended) on
// the way out. Faulting accesses leave memory untouched and return zero data.
module data_mem_pipe #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_func3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         AW       = $clog2(DEPTH_BYTES);
    localparam int         WORDS    = DEPTH_BYTES / 4;
    localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

    // Elaboration-time parameter legality checks.
    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_mem_pipe: DATA_W must be 32");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("data_mem_pipe: LATENCY must be in 1..4");
    end
    if (DEPTH_BYTES < 16 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("data_mem_pipe: DEPTH_BYTES must be a power of two >= 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        accept;
    logic [2:0]  size;
    logic        fmt_bad;
    logic        misaligned;
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        req_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic        mem_we;
    logic [AW-3:0] word_idx;
    logic [31:0] rd_word;

    // Captured request attributes needed to build the response.
    logic        we_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic        err_q;

    logic [31:0] shifted;
    logic [31:0] load_data;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW-1:2];

    // Decode access size and all fault conditions from the live request.
    always_comb begin
        case (req_func3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        size = 3'd0;
        endcase
        fmt_bad      = (size == 3'd0) || (req_we && req_func3[2]);
        misaligned   = ((size == 3'd2) && req_addr[0]) ||
                       ((size == 3'd4) && (req_addr[1:0] != 2'b00));
        // 33-bit sum so an access near the top of the address space cannot wrap.
        end_addr     = {1'b0, req_addr} + {30'b0, size} - 33'd1;
        out_of_range = (end_addr >= 33'(DEPTH_BYTES));
        req_err      = fmt_bad || misaligned || out_of_range;
    end

    // Byte-lane enables and lane-aligned store data (little-endian placement).
    always_comb begin
        case (size)
            3'd1:    byte_en = 4'b0001 << req_addr[1:0];
            3'd2:    byte_en = 4'b0011 << req_addr[1:0];
            3'd4:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        wdata_lane = req_wdata << {req_addr[1:0], 3'b000};
        // A request presented while reset is held must not disturb memory.
        mem_we     = accept && req_we && !req_err && rst_n;
    end

    // One narrow RAM per byte lane so each lane has a plain write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q;

        // Lane RAM: read-before-write, so a same-edge read sees old contents.
        always_ff @(posedge clk) begin
            if (mem_we && byte_en[gi]) begin
                mem[word_idx] <= wdata_lane[8*gi +: 8];
            end
            if (accept) begin
                rd_q <= mem[word_idx];
            end
        end

        assign rd_word[8*gi +: 8] = rd_q;
    end

    // Capture the request attributes on accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            func3_q <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            func3_q <= req_func3;
            off_q   <= req_addr[1:0];
            err_q   <= req_err;
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter starts at 1 on accept so RESP lands LATENCY-1 edges later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Extract and extend the load result from the registered RAM word.
    always_comb begin
        shifted = rd_word >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            3'b010:  load_data = shifted;
            default: load_data = 32'b0;
        endcase
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'b0;
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: directed vector table, stall and
// reset sequences, then randomized traffic against a byte-array reference model.
module tb_data_mem_pipe;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [40];
    int   nvec = 0;

    data_mem_pipe #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT),
        .DATA_W     (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_func3 (req_func3),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (txn %0d)", name, act, exp, txn);
        end
    endtask

    // Reference model: byte array, size rules, little-endian assembly, extension.
    function automatic void model(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int          size;
        longint      a;
        logic [63:0] val;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        a   = longint'({32'b0, addr});
        err = (size == 0) || (we && f3[2]);
        if (!err) err = ((a % size) != 0) || (a + size > DEPTH);
        rd = 32'b0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            end else begin
                val = 64'b0;
                for (int k = 0; k < size; k++) val |= 64'(ref_mem[int'(a) + k]) << (8 * k);
                if (!f3[2] && size < 4 && val[8*size-1]) val |= ~((64'd1 << (8 * size)) - 64'd1);
                rd = val[31:0];
            end
        end
    endfunction

    task automatic add(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] rd, input bit err);
        vecs[nvec] = '{we, addr, f3, wd, rd, err};
        nvec++;
    endtask

    // Present a request at a falling edge and return #1 after its accept edge.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        int w = 0;
        req_we    = we;
        req_addr  = addr;
        req_func3 = f3;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the captured request must not change.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_func3 = 3'($urandom);
        req_wdata = $urandom;
    endtask

    // Wait for the response, check it, optionally stall the consumer, then handshake.
    task automatic finish(input logic [31:0] exp_rd, input bit exp_err, input int stall,
                          output logic [31:0] got_rd, output bit got_err, output int lat);
        resp_ready = (stall == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk("latency", 32'(lat), 32'(LAT));
        chk("rdata", resp_rdata, exp_rd);
        chk("err", 32'(resp_err), 32'(exp_err));
        got_rd  = resp_rdata;
        got_err = resp_err;
        if (resp_valid) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, exp_rd);
                chk("hold_err", 32'(resp_err), 32'(exp_err));
                chk("hold_busy", 32'(req_ready), 32'd0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
    endtask

    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                           input int stall);
        logic [31:0] rd;
        bit          e;
        int          lat;
        txn++;
        issue(we, addr, f3, wd);
        finish(exp_rd, exp_err, stall, rd, e, lat);
        $display("txn %0d we=%0b f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d (exp %h/%0b)",
                 txn, we, f3, addr, wd, rd, e, lat, exp_rd, exp_err);
    endtask

    initial begin
        logic [31:0] erd;
        bit          eerr;
        logic [31:0] rd;
        bit          e;
        int          lat;
        bit          rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        logic [31:0] rwd;
        int          sel;

        clk        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'b0;
        req_func3  = 3'b0;
        req_wdata  = 32'b0;
        resp_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Give every byte a defined value so random loads have known expectations.
        for (int w = 0; w < DEPTH / 4; w++) begin
            rwd = $urandom;
            model(1'b1, 32'(w * 4), 3'd2, rwd, erd, eerr);
            run_txn(1'b1, 32'(w * 4), 3'd2, rwd, erd, eerr, 0);
        end

        // Directed vectors: {we, addr, func3, wdata, expected rdata, expected err}.
        add(1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h00000000, 0);
        add(0, 32'h10,  3'd2, 32'h0,        32'hDEADBEEF, 0);
        add(0, 32'h13,  3'd0, 32'h0,        32'hFFFFFFDE, 0);
        add(0, 32'h13,  3'd4, 32'h0,        32'h000000DE, 0);
        add(0, 32'h10,  3'd1, 32'h0,        32'hFFFFBEEF, 0);
        add(0, 32'h12,  3'd5, 32'h0,        32'h0000DEAD, 0);
        add(0, 32'h12,  3'd0, 32'h0,        32'hFFFFFFAD, 0);
        add(1, 32'h20,  3'd2, 32'hCAFEF00D, 32'h00000000, 0);
        add(1, 32'h22,  3'd2, 32'h11223344, 32'h00000000, 1);
        add(0, 32'h20,  3'd2, 32'h0,        32'hCAFEF00D, 0);
        add(1, 32'h3FF, 3'd0, 32'hAAAAAA7F, 32'h00000000, 0);
        add(0, 32'h3FE, 3'd2, 32'h0,        32'h00000000, 1);
        add(0, 32'h3FF, 3'd0, 32'h0,        32'h0000007F, 0);
        add(1, 32'h3FE, 3'd1, 32'h12348001, 32'h00000000, 0);
        add(0, 32'h3FE, 3'd1, 32'h0,        32'hFFFF8001, 0);
        add(0, 32'h3FF, 3'd4, 32'h0,        32'h00000080, 0);
        add(0, 32'h3FF, 3'd1, 32'h0,        32'h00000000, 1);
        add(0, 32'h11,  3'd1, 32'h0,        32'h00000000, 1);
        add(0, 32'h3FC, 3'd3, 32'h0,        32'h00000000, 1);
        add(0, 32'h10,  3'd6, 32'h0,        32'h00000000, 1);
        add(0, 32'h10,  3'd7, 32'h0,        32'h00000000, 1);
        add(1, 32'h20,  3'd4, 32'h000000FF, 32'h00000000, 1);
        add(1, 32'h20,  3'd5, 32'h0000FFFF, 32'h00000000, 1);
        add(0, 32'h20,  3'd2, 32'h0,        32'hCAFEF00D, 0);
        add(0, 32'h400, 3'd2, 32'h0,        32'h00000000, 1);
        add(0, 32'hFFFFFFFF, 3'd4, 32'h0,   32'h00000000, 1);
        add(1, 32'hFFFFFFFC, 3'd2, 32'h5,   32'h00000000, 1);
        add(1, 32'h21,  3'd0, 32'h00000055, 32'h00000000, 0);
        add(0, 32'h20,  3'd2, 32'h0,        32'hCAFE550D, 0);
        add(0, 32'h21,  3'd4, 32'h0,        32'h00000055, 0);
        for (int i = 0; i < nvec; i++) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, erd, eerr);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd,
                    vecs[i].exp_rd, vecs[i].exp_err, 0);
        end

        // Consumer stall with a second request held pending throughout.
        txn++;
        issue(1'b0, 32'h10, 3'd2, 32'h0);
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_func3 = 3'd2;
        req_wdata = 32'h600DF00D;
        req_valid = 1'b1;
        finish(32'hDEADBEEF, 1'b0, 5, rd, e, lat);
        $display("txn %0d stalled LW 0x10 -> rdata=%h err=%0b lat=%0d", txn, rd, e, lat);
        chk("ready_after_hs", 32'(req_ready), 32'd1);
        txn++;
        model(1'b1, 32'h40, 3'd2, 32'h600DF00D, erd, eerr);
        issue(1'b1, 32'h40, 3'd2, 32'h600DF00D);
        chk("busy_after_accept", 32'(req_ready), 32'd0);
        finish(32'h0, 1'b0, 0, rd, e, lat);
        $display("txn %0d held SW 0x40 -> rdata=%h err=%0b lat=%0d", txn, rd, e, lat);
        run_txn(1'b0, 32'h40, 3'd2, 32'h0, 32'h600DF00D, 1'b0, 0);

        // Reset during WAIT of a store (commit persists) and of a load (no response).
        for (int pass = 0; pass < 2; pass++) begin
            txn++;
            if (pass == 0) begin
                model(1'b1, 32'h30, 3'd2, 32'h0BADF00D, erd, eerr);
                issue(1'b1, 32'h30, 3'd2, 32'h0BADF00D);
            end else begin
                issue(1'b0, 32'h10, 3'd2, 32'h0);
            end
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrst_req_ready", 32'(req_ready), 32'd1);
            chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
            chk("midrst_resp_rdata", resp_rdata, 32'd0);
            chk("midrst_resp_err", 32'(resp_err), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
            end
            $display("txn %0d aborted by reset (pass %0d)", txn, pass);
            model(1'b0, 32'h30, 3'd2, 32'h0, erd, eerr);
            run_txn(1'b0, 32'h30, 3'd2, 32'h0, erd, eerr, 0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            rwe = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 19);
            if (sel < 17) begin
                case ($urandom_range(0, 4))
                    0: rf3 = 3'd0;
                    1: rf3 = 3'd1;
                    2: rf3 = 3'd2;
                    3: rf3 = 3'd4;
                    default: rf3 = 3'd5;
                endcase
            end else begin
                rf3 = 3'($urandom_range(0, 7));
            end
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                raddr = 32'($urandom_range(0, DEPTH - 1)) & ~32'((rf3[1:0] == 2'd2) ? 3 :
                                                                 (rf3[1:0] == 2'd1) ? 1 : 0);
            end else if (sel < 8) begin
                raddr = 32'($urandom_range(0, DEPTH - 1));
            end else if (sel == 8) begin
                raddr = 32'(DEPTH - $urandom_range(1, 4));
            end else begin
                raddr = $urandom;
            end
            rwd = $urandom;
            model(rwe, raddr, rf3, rwd, erd, eerr);
            run_txn(rwe, raddr, rf3, rwd, erd, eerr, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
